// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch debouncer.
package sw_pkg;

  localparam int unsigned DEBOUNCE_MS_50MHZ = 500000;
  localparam int unsigned SIM_CNT_MAX       = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, edge pulses.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEBOUNCE_MS_50MHZ,
  localparam int unsigned CNT_W  = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic chg_next
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             settle;

  always_comb begin
    settle = (s2_q != out_q) && (cnt_q == CntLast);
    out_d  = out_q;
    cnt_d  = cnt_q + CNT_W'(1);
    // Any agreement with the current output abandons the count.
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (settle) begin
      out_d = s2_q;
      cnt_d = '0;
    end
    rise_d = settle & s2_q;
    fall_d = settle & ~s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= in;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out      = out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  // Lets the parent register a summary flag aligned with rise/fall.
  assign chg_next = settle;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches and flags any settled edge.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned CNT_MAX = DEBOUNCE_MS_50MHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] chg_next;
  logic             any_change_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_MAX (CNT_MAX)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .in       (sw_in[i]),
      .out      (db_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .chg_next (chg_next[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |chg_next;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with CNT_MAX = 4, WIDTH = 10.
module tb_sw_debounce;
  import sw_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw_in;
  logic [9:0] db_out, rise, fall;
  logic       any_change;

  int n_cmp  = 0;
  int n_fail = 0;

  sw_debounce #(
    .WIDTH   (10),
    .CNT_MAX (SIM_CNT_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .db_out     (db_out),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int bad;

  initial begin
    rst   = 1'b1;
    sw_in = 10'h3FF;
    repeat (3) begin
      tick();
      chk("rst_db", 16'(db_out), 16'h000);
      chk("rst_rise", 16'(rise), 16'h000);
      chk("rst_fall", 16'(fall), 16'h000);
      chk("rst_any", 16'(any_change), 16'h0);
    end

    // Release: output follows on the 6th edge.
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("rel_wait_db", 16'(db_out), 16'h000);
    end
    tick();
    chk("rel_db", 16'(db_out), 16'h3FF);
    chk("rel_rise", 16'(rise), 16'h3FF);
    chk("rel_fall", 16'(fall), 16'h000);
    chk("rel_any", 16'(any_change), 16'h1);
    tick();
    chk("rel_rise_end", 16'(rise), 16'h000);
    chk("rel_any_end", 16'(any_change), 16'h0);

    // Drop all switches back to 0.
    sw_in = 10'h000;
    repeat (5) tick();
    chk("clr_wait_db", 16'(db_out), 16'h3FF);
    tick();
    chk("clr_db", 16'(db_out), 16'h000);
    chk("clr_fall", 16'(fall), 16'h3FF);
    chk("clr_any", 16'(any_change), 16'h1);
    repeat (3) tick();

    // Clean step on bit 0.
    sw_in = 10'h001;
    repeat (5) begin
      tick();
      chk("step_wait_db", 16'(db_out), 16'h000);
    end
    tick();
    chk("step_db", 16'(db_out), 16'h001);
    chk("step_rise", 16'(rise), 16'h001);
    chk("step_fall", 16'(fall), 16'h000);
    tick();
    chk("step_rise_end", 16'(rise), 16'h000);

    // Bounce on bit 1: 1,0,1,0 then settle at 1.
    bad = 0;
    sw_in[1] = 1'b1; tick(); if (db_out != 10'h001 || rise != 10'h000) bad++;
    sw_in[1] = 1'b0; tick(); if (db_out != 10'h001 || rise != 10'h000) bad++;
    sw_in[1] = 1'b1; tick(); if (db_out != 10'h001 || rise != 10'h000) bad++;
    sw_in[1] = 1'b0; tick(); if (db_out != 10'h001 || rise != 10'h000) bad++;
    sw_in[1] = 1'b1;
    repeat (5) begin
      tick();
      if (db_out != 10'h001 || rise != 10'h000) bad++;
    end
    chk("bounce_hold", 16'(bad), 16'd0);
    tick();
    chk("bounce_db", 16'(db_out), 16'h003);
    chk("bounce_rise", 16'(rise), 16'h002);
    bad = 0;
    repeat (6) begin
      tick();
      if (rise != 10'h000) bad++;
    end
    chk("bounce_one_pulse", 16'(bad), 16'd0);

    // Three-cycle glitch on bit 2 must be swallowed.
    bad = 0;
    sw_in[2] = 1'b1;
    repeat (3) tick();
    sw_in[2] = 1'b0;
    repeat (8) begin
      tick();
      if (db_out != 10'h003 || rise != 10'h000 || fall != 10'h000 || any_change) bad++;
    end
    chk("glitch_quiet", 16'(bad), 16'd0);
    chk("glitch_db", 16'(db_out), 16'h003);

    sw_in = 10'h000;
    repeat (10) tick();
    chk("idle_db", 16'(db_out), 16'h000);

    // Bits 0 and 2 settle on the same edge.
    sw_in = 10'h005;
    repeat (5) begin
      tick();
      chk("sim_wait_db", 16'(db_out), 16'h000);
    end
    tick();
    chk("sim_db", 16'(db_out), 16'h005);
    chk("sim_rise", 16'(rise), 16'h005);
    chk("sim_any", 16'(any_change), 16'h1);
    tick();
    chk("sim_any_end", 16'(any_change), 16'h0);
    chk("sim_rise_end", 16'(rise), 16'h000);

    // Reset with bit 3's count at 2.
    sw_in = 10'h00D;
    repeat (4) tick();
    chk("mid_pre_db", 16'(db_out), 16'h005);
    rst = 1'b1;
    tick();
    chk("mid_rst_db", 16'(db_out), 16'h000);
    chk("mid_rst_rise", 16'(rise), 16'h000);
    chk("mid_rst_fall", 16'(fall), 16'h000);
    chk("mid_rst_any", 16'(any_change), 16'h0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("mid_wait_rise", 16'(rise), 16'h000);
    end
    tick();
    chk("mid_db", 16'(db_out), 16'h00D);
    chk("mid_rise", 16'(rise), 16'h00D);
    chk("mid_any", 16'(any_change), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
